// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   BE_* : canonical lane-aligned byte-enable patterns
//   rsp_t: response payload carried through the response FIFO
//   be_legal(): byte-enable / address-offset legality check
package dmem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  typedef struct packed {
    logic [DATA_W-1:0] rdata;
    logic              we;
    logic              err;
  } rsp_t;

  localparam int unsigned RSP_W = $bits(rsp_t);

  // True when the byte enables form a naturally aligned access at this offset.
  function automatic logic be_legal(input logic [3:0] be, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    if ((be == BE_WORD) && (off == 2'd0))    ok = 1'b1;
    if ((be == BE_HALF_LO) && (off == 2'd0)) ok = 1'b1;
    if ((be == BE_HALF_HI) && (off == 2'd2)) ok = 1'b1;
    if (be == 4'(BE_BYTE0 << off))           ok = 1'b1;
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// Synchronous FIFO with register-array storage and registered valid/count.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i/data_i : write port (dropped only if full without a same-cycle pop)
//   pop_i         : consume head (ignored while empty)
//   valid_o/data_o: head entry, stable until popped
//   count_o       : current occupancy
module dmem_rsp_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 34,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q;
  logic             do_push, do_pop;

  // Pointer increment with wrap for non-power-of-two depths.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i & valid_q;
  assign do_push = push_i & ((cnt_q != CNT_W'(DEPTH)) | do_pop);

  // Next-state pointers and occupancy.
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = ptr_inc(wptr_q);
    if (do_pop)  rptr_d = ptr_inc(rptr_q);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != '0);
      if (do_push) mem_q[wptr_q] <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-port memory responder: owns the data RAM, accepts load/store requests
// under credit control and returns one in-order response per request.
//   clk_i, rst_ni          : clock, async active-low reset
//   req_valid_i/req_ready_o: request handshake (ready from registers only)
//   req_we_i/addr/be/wdata : request fields (byte address, lane-aligned data)
//   rsp_valid_o/rsp_ready_i: response handshake
//   rsp_rdata_o/we_o/err_o : response payload
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 13,
  parameter int unsigned LAT       = 1,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [3:0]  req_be_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_we_o,
  output logic        rsp_err_o
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned WORDS = 2 ** ADDR_W;

  logic [31:0]       ram_q [WORDS];
  logic [ADDR_W-1:0] word_idx;
  logic              legal;
  logic              accept;
  logic              pop;
  logic              ready_q, ready_d;
  rsp_t              ent_c;
  rsp_t              push_data;
  rsp_t              head;
  logic              push;
  logic              pipe_occ;
  logic              fifo_valid;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [CNT_W:0]    out_cur, out_nxt;

  assign word_idx = req_addr_i[ADDR_W+1:2];
  assign legal    = (req_addr_i[31:ADDR_W+2] == '0) && be_legal(req_be_i, req_addr_i[1:0]);
  assign accept   = req_valid_i & ready_q;
  assign pop      = fifo_valid & rsp_ready_i;

  // Response entry formed at accept; the RAM word is sampled at the accept edge.
  always_comb begin
    ent_c       = '0;
    ent_c.err   = ~legal;
    ent_c.we    = req_we_i;
    ent_c.rdata = (legal && !req_we_i) ? ram_q[word_idx] : '0;
  end

  // Byte-lane RAM write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (accept && legal && req_we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (req_be_i[b]) ram_q[word_idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  // Optional second latency stage; never stalls because credits reserve FIFO space.
  if (LAT >= 2) begin : g_pipe
    rsp_t pipe_q;
    logic pipe_v_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pipe_q   <= '0;
        pipe_v_q <= 1'b0;
      end else begin
        pipe_q   <= ent_c;
        pipe_v_q <= accept;
      end
    end
    assign push      = pipe_v_q;
    assign push_data = pipe_q;
    assign pipe_occ  = pipe_v_q;
  end else begin : g_nopipe
    assign push      = accept;
    assign push_data = ent_c;
    assign pipe_occ  = 1'b0;
  end

  dmem_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (RSP_W)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .valid_o (fifo_valid),
    .data_o  (head),
    .count_o (fifo_cnt)
  );

  // Outstanding credits = pipe + FIFO; ready is the registered "room left" flag.
  always_comb begin
    out_cur = (CNT_W+1)'(fifo_cnt) + (CNT_W+1)'(pipe_occ);
    out_nxt = out_cur + (CNT_W+1)'(accept) - (CNT_W+1)'(pop);
    ready_d = (out_nxt < (CNT_W+1)'(RSP_DEPTH));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ready_q <= 1'b1;
    else         ready_q <= ready_d;
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = fifo_valid;
  assign rsp_rdata_o = head.rdata;
  assign rsp_we_o    = head.we;
  assign rsp_err_o   = head.err;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned ADDR_W    = 13;
  localparam int unsigned LAT       = 1;
  localparam int unsigned RSP_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_we;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .ADDR_W    (ADDR_W),
    .LAT       (LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_be_i    (req_be),
    .req_wdata_i (req_wdata),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_we_o    (rsp_we),
    .rsp_err_o   (rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_be    = be;
    req_wdata = wd;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    #13;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_we !== 1'b0 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%0b rdata=%h we=%0b err=%0b, want all 0",
               rsp_valid, rsp_rdata, rsp_we, rsp_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %0b, want 1", req_ready);
    end
  endtask

  task automatic test_store_load();
    rsp_ready = 1'b1;
    drive(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL t1_store_rsp: got v=%0b we=%0b err=%0b rdata=%h, want v=1 we=1 err=0 rdata=0",
               rsp_valid, rsp_we, rsp_err, rsp_rdata);
    end
    drive(1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL t1_load_rsp: got v=%0b we=%0b err=%0b rdata=%h, want v=1 we=0 err=0 rdata=deadbeef",
               rsp_valid, rsp_we, rsp_err, rsp_rdata);
    end
    idle();
    tick();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL t1_drained: got v=%0b, want 0", rsp_valid);
    end
  endtask

  task automatic test_byte_store();
    rsp_ready = 1'b1;
    drive(1'b1, 32'h12, 4'b0100, 32'h00AA0000);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL t2_store_rsp: got v=%0b we=%0b err=%0b, want v=1 we=1 err=0",
               rsp_valid, rsp_we, rsp_err);
    end
    drive(1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hDEAABEEF) begin
      fails++;
      $display("FAIL t2_load_rsp: got v=%0b err=%0b rdata=%h, want v=1 err=0 rdata=deaabeef",
               rsp_valid, rsp_err, rsp_rdata);
    end
    idle();
    tick();
  endtask

  task automatic test_backpressure();
    int acc;
    acc = 0;
    rsp_ready = 1'b0;
    drive(1'b0, 32'h10, 4'hF, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (req_ready) acc++;
      tick();
    end
    idle();
    tests++;
    if (acc !== 2 || req_ready !== 1'b0) begin
      fails++;
      $display("FAIL t3_credit_stop: got accepts=%0d ready=%0b, want accepts=2 ready=0", acc, req_ready);
    end
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAABEEF) begin
      fails++;
      $display("FAIL t3_head_held: got v=%0b rdata=%h, want v=1 rdata=deaabeef", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAABEEF) begin
      fails++;
      $display("FAIL t3_after_pop: got ready=%0b v=%0b rdata=%h, want ready=1 v=1 rdata=deaabeef",
               req_ready, rsp_valid, rsp_rdata);
    end
    tick();
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL t3_drained: got v=%0b ready=%0b, want v=0 ready=1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_errors();
    rsp_ready = 1'b1;
    drive(1'b1, 32'h0, 4'hF, 32'hCAFEF00D);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_err !== 1'b0) begin
      fails++;
      $display("FAIL t4_init_store: got v=%0b we=%0b err=%0b, want v=1 we=1 err=0",
               rsp_valid, rsp_we, rsp_err);
    end
    drive(1'b0, 32'h11, 4'b0011, 32'h0);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL t4_bad_be: got v=%0b we=%0b err=%0b rdata=%h, want v=1 we=0 err=1 rdata=0",
               rsp_valid, rsp_we, rsp_err, rsp_rdata);
    end
    drive(1'b1, 32'h0004_0000, 4'hF, 32'h12345678);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_we !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL t4_out_of_range: got v=%0b we=%0b err=%0b rdata=%h, want v=1 we=1 err=1 rdata=0",
               rsp_valid, rsp_we, rsp_err, rsp_rdata);
    end
    drive(1'b0, 32'h0, 4'hF, 32'h0);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_rdata !== 32'hCAFEF00D) begin
      fails++;
      $display("FAIL t4_word0_intact: got v=%0b err=%0b rdata=%h, want v=1 err=0 rdata=cafef00d",
               rsp_valid, rsp_err, rsp_rdata);
    end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_flight();
    rsp_ready = 1'b0;
    drive(1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    tick();
    idle();
    tests++;
    if (rsp_valid !== 1'b1) begin
      fails++;
      $display("FAIL t5_pending: got v=%0b, want 1", rsp_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0) begin
      fails++;
      $display("FAIL t5_async_clear: got v=%0b rdata=%h, want v=0 rdata=0", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        fails++;
        $display("FAIL t5_quiet_%0d: got v=%0b ready=%0b, want v=0 ready=1", i, rsp_valid, req_ready);
      end
    end
    drive(1'b0, 32'h10, 4'hF, 32'h0);
    tick();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAABEEF) begin
      fails++;
      $display("FAIL t5_ram_kept: got v=%0b rdata=%h, want v=1 rdata=deaabeef", rsp_valid, rsp_rdata);
    end
    idle();
    tick();
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] mask;
    logic        we;
    logic        err;
  } exp_t;

  task automatic test_random_traffic();
    exp_t        q[$];
    exp_t        e;
    logic [31:0] mdl   [8];
    logic [3:0]  known [8];
    int          acc, rsps, outst, maxout;
    logic        acc_now, pop_now, lgl;
    logic [2:0]  idx;
    logic [1:0]  off;
    logic [3:0]  be;
    logic [31:0] addr;
    acc = 0; rsps = 0; outst = 0; maxout = 0;
    for (int i = 0; i < 8; i++) begin
      mdl[i] = '0;
      known[i] = '0;
    end
    idle();
    rsp_ready = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!req_valid && cyc < 350 && $urandom_range(0, 3) != 0) begin
        idx = 3'($urandom_range(0, 7));
        off = 2'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
          0:       be = 4'b1111;
          1:       be = 4'b0011;
          2:       be = 4'b1100;
          3:       be = 4'b0001 << off;
          default: be = 4'($urandom_range(0, 15));
        endcase
        addr = 32'h100 + {27'd0, idx, 2'd0} + {30'd0, off};
        if ($urandom_range(0, 7) == 0) addr = addr | 32'h0010_0000;
        drive(1'($urandom_range(0, 1)), addr, be, $urandom);
      end
      acc_now = req_valid & req_ready;
      pop_now = rsp_valid & rsp_ready;
      tests++;
      if (req_ready !== (outst < RSP_DEPTH)) begin
        fails++;
        $display("FAIL t6_ready_c%0d: got %0b, want %0b (outstanding=%0d)",
                 cyc, req_ready, (outst < RSP_DEPTH), outst);
      end
      if (pop_now) begin
        rsps++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL t6_extra_rsp_c%0d: got response with none expected", cyc);
        end else begin
          e = q.pop_front();
          if (rsp_we !== e.we || rsp_err !== e.err || ((rsp_rdata ^ e.rdata) & e.mask) !== 32'h0) begin
            fails++;
            $display("FAIL t6_rsp_c%0d: got we=%0b err=%0b rdata=%h, want we=%0b err=%0b rdata=%h mask=%h",
                     cyc, rsp_we, rsp_err, rsp_rdata, e.we, e.err, e.rdata, e.mask);
          end
        end
      end
      if (acc_now) begin
        idx = req_addr[4:2];
        off = req_addr[1:0];
        lgl = (req_addr[31:15] == 17'd0) &&
              ((req_be == 4'b1111 && off == 2'd0) || (req_be == 4'b0011 && off == 2'd0) ||
               (req_be == 4'b1100 && off == 2'd2) || (req_be == 4'b0001 && off == 2'd0) ||
               (req_be == 4'b0010 && off == 2'd1) || (req_be == 4'b0100 && off == 2'd2) ||
               (req_be == 4'b1000 && off == 2'd3));
        e.we   = req_we;
        e.err  = ~lgl;
        e.rdata = 32'h0;
        e.mask  = 32'hFFFF_FFFF;
        if (lgl && !req_we) begin
          e.rdata = mdl[idx];
          for (int b = 0; b < 4; b++) e.mask[8*b +: 8] = {8{known[idx][b]}};
        end
        q.push_back(e);
        if (lgl && req_we) begin
          for (int b = 0; b < 4; b++) begin
            if (req_be[b]) begin
              mdl[idx][8*b +: 8] = req_wdata[8*b +: 8];
              known[idx][b] = 1'b1;
            end
          end
        end
        acc++;
      end
      tick();
      outst = outst + (acc_now ? 1 : 0) - (pop_now ? 1 : 0);
      if (outst > maxout) maxout = outst;
      if (acc_now) idle();
      rsp_ready = ~rsp_ready;
    end
    tests++;
    if (acc !== rsps || q.size() != 0 || req_valid !== 1'b0) begin
      fails++;
      $display("FAIL t6_balance: got accepts=%0d responses=%0d left=%0d pending=%0b, want equal, 0 left, 0 pending",
               acc, rsps, q.size(), req_valid);
    end
    tests++;
    if (maxout > RSP_DEPTH || acc < 50) begin
      fails++;
      $display("FAIL t6_occupancy: got max_outstanding=%0d accepts=%0d, want <=%0d and >=50",
               maxout, acc, RSP_DEPTH);
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_store();
    test_backpressure();
    test_errors();
    test_reset_mid_flight();
    test_random_traffic();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the data port. Owns the data RAM and services load/store requests from the memory stage.
- Uses a valid/ready request channel and an in-order, back-pressurable response channel.
- Enforces byte-lane legality and address range, with a fixed read latency and credit-based request acceptance.

Parameters:
- ADDR_W, 13, word-address bits; RAM depth is 2**ADDR_W 32-bit words.
- LAT, 1, read latency in cycles (legal values 1 or 2).
- RSP_DEPTH, 2, maximum outstanding requests: in the latency pipe plus queued in the response FIFO (2..8).

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_addr_i  in  32  byte address.
- req_be_i  in  4  byte enables, already lane-aligned by the requester.
- req_wdata_i  in  32  store data, lane-aligned.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response ready.
- rsp_rdata_o  out  32  full read word (loads); 0 for stores and errors.
- rsp_we_o  out  1  echo of req_we_i for this response.
- rsp_err_o  out  1  request was illegal; no RAM side effect.

Behaviour:
- Handshake: a request is accepted in any cycle where req_valid_i & req_ready_o; one request per cycle.
- req_valid_i may not be withdrawn until accepted. Request fields stay stable while valid.
- Credits:
  - outstanding = entries in the latency pipe + entries in the response FIFO.
  - req_ready_o = (outstanding < RSP_DEPTH). It is driven from registers only and never from rsp_ready_i or req_valid_i.
  - outstanding is incremented on accept and decremented on rsp_valid_o & rsp_ready_i. Both in one cycle leave it unchanged.
- Legality: err = 1 when either condition holds:
  - req_addr_i[31:ADDR_W+2] != 0 (out of range).
  - req_be_i does not match req_addr_i[1:0]. The legal pairs are:
    - be=1111 with off=00.
    - be=0011 with off=00.
    - be=1100 with off=10.
    - be=(0001<<off) for any off.
  - All other values, including be=0000, are errors.
- Stores: legal stores update only the enabled byte lanes of word req_addr_i[ADDR_W+1:2], at the accept edge.
- Loads: a legal load reads the whole word synchronously.
  - Sub-word extraction and sign extension are the requester's job.
  - A load accepted the cycle after a store to the same word returns the new data, since the write lands at the earlier edge.
- Latency:
  - A request accepted in cycle c produces rsp_valid_o in cycle c+LAT at the earliest. It is later only if older responses are still queued.
  - The latency pipe never stalls. This is safe because credits guarantee the FIFO has space on arrival.
- Ordering: responses return strictly in acceptance order. Stores and errored requests also produce exactly one response, with the same latency.
- Response FIFO:
  - RSP_DEPTH entries, registered head. rsp_* fields show the head while rsp_valid_o = 1.
  - The head holds stable until popped.
  - A simultaneous push and pop is legal at any occupancy.
  - Pointers wrap modulo RSP_DEPTH.
- Reset (rst_ni=0, asynchronous):
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_we_o=0, rsp_err_o=0.
  - The pipe and FIFO are emptied and outstanding=0. req_ready_o=1 from the first cycle after release.
  - Reset mid-operation discards all in-flight responses. Stores already accepted remain in the RAM.
  - RAM contents are never reset.

Decomposition:
- Shared package dmem_pkg:
  - BE_WORD=4'b1111, BE_HALF_LO=4'b0011, BE_HALF_HI=4'b1100, BE_BYTE0=4'b0001.
  - A response struct/typedef {rdata[31:0], we, err}.
  - A function be_legal(be, off).
- Sub-module: dmem_rsp_fifo, a synchronous FIFO parameterised on depth and width, with count output. The RAM stays inferred inside dmem_responder.

Test Plan:
1. Store addr=0x10, be=1111, wdata=0xDEADBEEF, then load addr=0x10 next cycle, rsp_ready_i=1 -> two responses in order: {we=1, err=0, rdata=0}, then {we=0, err=0, rdata=0xDEADBEEF}; load response LAT cycles after its accept.
2. Store addr=0x12, be=0100 (byte 0xAA in lane 2, wdata=0x00AA0000), then load addr=0x10 -> rdata=0xDEAAEEF... sequence gives 0xDEAABEEF; lanes 0, 1, 3 unchanged.
3. rsp_ready_i=0, four back-to-back loads, RSP_DEPTH=2 -> exactly two accepted, req_ready_o=0 thereafter; raise rsp_ready_i -> responses drain in order, req_ready_o returns high the cycle after the first pop.
4. Load addr=0x11, be=0011, and store addr=0x4_0000 (out of range for ADDR_W=13), be=1111 -> both respond with err=1, rdata=0; a later load of word 0 shows no change.
5. Issue two loads, assert rst_ni=0 before their responses -> rsp_valid_o drops immediately, no responses after release, req_ready_o=1; an earlier completed store is still readable.
6. Randomized back-to-back traffic with rsp_ready_i toggling every cycle -> the number of responses equals the number of accepts, order is preserved, and outstanding never exceeds RSP_DEPTH.
